// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard unit: forwarding selects, stage indices
// and the scoreboard entry kept for each in-flight instruction.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_t;

    localparam int STG_F = 0;
    localparam int STG_D = 1;
    localparam int STG_E = 2;
    localparam int STG_M = 3;
    localparam int STG_W = 4;

    // Entries hold dst at a fixed width so the struct can live in the package.
    localparam int SB_DST_W = 8;

    typedef struct packed {
        logic                valid;
        logic [SB_DST_W-1:0] dst;
        logic                wen;
        logic                load;
        logic                mem;
    } sb_entry_t;

    function automatic fwd_sel_t fwd_pick(input logic hit_e, input logic hit_m,
                                          input logic hit_w, input logic e_is_load);
        if (hit_e && !e_is_load) return FWD_E;
        if (hit_m) return FWD_M;
        if (hit_w) return FWD_W;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// D-stage description, memory/branch status and the resulting pipeline
// control signals exchanged between the decoder side and the hazard unit.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              d_valid;
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic              d_rs_used;
    logic              d_rt_used;
    logic [REG_AW-1:0] d_dst;
    logic              d_wen;
    logic              d_load;
    logic              d_mem;
    logic              br_taken;
    logic              mem_ready;

    logic              stall_f;
    logic              stall_d;
    logic              flush_fd;
    logic              flush_de;
    logic              flush_em;
    logic              redirect;
    logic              freeze;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output d_valid, d_rs, d_rt, d_rs_used, d_rt_used, d_dst, d_wen, d_load, d_mem,
        output br_taken, mem_ready,
        input  stall_f, stall_d, flush_fd, flush_de, flush_em, redirect, freeze,
        input  fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_rs_used, d_rt_used, d_dst, d_wen, d_load, d_mem,
        input  br_taken, mem_ready,
        output stall_f, stall_d, flush_fd, flush_de, flush_em, redirect, freeze,
        output fwd_a, fwd_b, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sb_match.sv
// Compares one D-stage source register against one scoreboard entry.
module sb_match
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              used,
    input  sb_entry_t         entry,
    output logic              hit
);

    // Register 0 never carries a produced value, so it can never match.
    assign hit = used && (src != '0) && entry.valid && entry.wen &&
                 (entry.dst == SB_DST_W'(src));

    logic unused_fields;
    assign unused_fields = ^{entry.load, entry.mem};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flow-control unit: tracks E/M/W occupancy and drives stalls,
// flushes, memory freeze and forwarding selects for the 5-stage pipeline.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW        = 5,
    parameter int RESOLVE_STAGE = 3,
    parameter int CNT_W         = 32
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);

    if (RESOLVE_STAGE != STG_E && RESOLVE_STAGE != STG_M) begin : g_bad_resolve
        $error("pipe_hazard_ctrl: RESOLVE_STAGE must be 2 (E) or 3 (M)");
    end
    if (REG_AW > SB_DST_W) begin : g_bad_aw
        $error("pipe_hazard_ctrl: REG_AW exceeds scoreboard dst width");
    end

    sb_entry_t        sb_e, sb_m, sb_w;
    sb_entry_t        stage_view [3];
    sb_entry_t        d_entry;
    sb_entry_t        res_entry;
    logic [2:0]       hit_a, hit_b;
    logic             frz_c, br_c, lu_c, stall_c, flush_de_c, flush_em_c;
    fwd_sel_t         fwd_a_c, fwd_b_c;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    assign stage_view[0] = sb_e;
    assign stage_view[1] = sb_m;
    assign stage_view[2] = sb_w;

    for (genvar s = 0; s < 3; s++) begin : g_match
        sb_match #(.REG_AW(REG_AW)) u_match_a (
            .src(bus.d_rs), .used(bus.d_rs_used), .entry(stage_view[s]), .hit(hit_a[s])
        );
        sb_match #(.REG_AW(REG_AW)) u_match_b (
            .src(bus.d_rt), .used(bus.d_rt_used), .entry(stage_view[s]), .hit(hit_b[s])
        );
    end

    assign d_entry   = {bus.d_valid, SB_DST_W'(bus.d_dst), bus.d_wen, bus.d_load, bus.d_mem};
    assign res_entry = (RESOLVE_STAGE == STG_M) ? sb_m : sb_e;

    // Priority chain: freeze masks everything, a taken branch kills the D instruction.
    assign frz_c      = sb_m.valid && sb_m.mem && !bus.mem_ready;
    assign br_c       = !frz_c && res_entry.valid && bus.br_taken;
    assign lu_c       = !frz_c && !br_c &&
                        (((hit_a[0] || hit_b[0]) && sb_e.load) ||
                         ((hit_a[1] || hit_b[1]) && sb_m.load));
    assign stall_c    = frz_c || lu_c;
    assign flush_de_c = br_c || lu_c;
    assign flush_em_c = br_c && (RESOLVE_STAGE == STG_M);

    assign fwd_a_c = frz_c ? FWD_RF : fwd_pick(hit_a[0], hit_a[1], hit_a[2], sb_e.load);
    assign fwd_b_c = frz_c ? FWD_RF : fwd_pick(hit_b[0], hit_b[1], hit_b[2], sb_e.load);

    assign bus.stall_f   = stall_c;
    assign bus.stall_d   = stall_c;
    assign bus.flush_fd  = br_c;
    assign bus.flush_de  = flush_de_c;
    assign bus.flush_em  = flush_em_c;
    assign bus.redirect  = br_c;
    assign bus.freeze    = frz_c;
    assign bus.fwd_a     = fwd_a_c;
    assign bus.fwd_b     = fwd_b_c;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

    // While frozen E and M hold their instructions and W drains to a bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sb_e        <= '0;
            sb_m        <= '0;
            sb_w        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (frz_c) begin
                sb_w <= '0;
            end else begin
                sb_w <= sb_m;
                sb_m <= flush_em_c ? '0 : sb_e;
                sb_e <= flush_de_c ? '0 : d_entry;
            end
            if (stall_c && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (br_c && !(&flush_cnt_q))    flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl with branches resolved in M:
// the driver queues hand-computed expectations, a negedge monitor checks them.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_used;
        logic       rt_used;
        logic [4:0] dst;
        logic       wen;
        logic       load;
        logic       mem;
    } dinst_t;

    typedef struct {
        string       name;
        logic [10:0] ctrl;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q [$];
    int   checks;
    int   errors;
    int   acc_s;
    int   acc_f;

    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus ();

    pipe_hazard_ctrl #(.REG_AW(5), .RESOLVE_STAGE(3), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic dinst_t ins(input logic v, input logic [4:0] a_rs, input logic [4:0] a_rt,
                                   input logic ru, input logic tu, input logic [4:0] a_dst,
                                   input logic w, input logic ld, input logic m);
        return '{valid: v, rs: a_rs, rt: a_rt, rs_used: ru, rt_used: tu,
                 dst: a_dst, wen: w, load: ld, mem: m};
    endfunction

    function automatic dinst_t nop();
        return ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic dinst_t alu(input logic [4:0] a_dst, input logic [4:0] a_rs, input logic [4:0] a_rt);
        return ins(1, a_rs, a_rt, 1, 1, a_dst, 1, 0, 0);
    endfunction
    function automatic dinst_t ldw(input logic [4:0] a_dst, input logic [4:0] a_rs);
        return ins(1, a_rs, 0, 1, 0, a_dst, 1, 1, 1);
    endfunction
    function automatic dinst_t st(input logic [4:0] a_rs, input logic [4:0] a_rt);
        return ins(1, a_rs, a_rt, 1, 1, 0, 0, 0, 1);
    endfunction
    function automatic dinst_t rdo(input logic [4:0] a_rs, input logic [4:0] a_rt);
        return ins(1, a_rs, a_rt, 1, 1, 0, 0, 0, 0);
    endfunction

    // Packs {stall_f, stall_d, flush_fd, flush_de, flush_em, redirect, freeze, fwd_a, fwd_b}.
    function automatic logic [10:0] ex(input logic stl, input logic ffd, input logic fde,
                                       input logic fem, input logic rdr, input logic frz,
                                       input logic [1:0] fa, input logic [1:0] fb);
        return {stl, stl, ffd, fde, fem, rdr, frz, fa, fb};
    endfunction

    task automatic applyStimulus(input string name, input dinst_t d, input logic br,
                                 input logic mr, input logic rst, input logic [10:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        bus.d_valid   = d.valid;
        bus.d_rs      = d.rs;
        bus.d_rt      = d.rt;
        bus.d_rs_used = d.rs_used;
        bus.d_rt_used = d.rt_used;
        bus.d_dst     = d.dst;
        bus.d_wen     = d.wen;
        bus.d_load    = d.load;
        bus.d_mem     = d.mem;
        bus.br_taken  = br;
        bus.mem_ready = mr;
        reset         = rst;
        e.name = name;
        e.ctrl = ec;
        e.scnt = 32'(acc_s);
        e.fcnt = 32'(acc_f);
        exp_q.push_back(e);
        if (!rst) begin
            acc_s = 0;
            acc_f = 0;
        end else begin
            acc_s += int'(ec[9]);
            acc_f += int'(ec[5]);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [10:0] act_ctrl;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act_ctrl = {bus.stall_f, bus.stall_d, bus.flush_fd, bus.flush_de, bus.flush_em,
                        bus.redirect, bus.freeze, bus.fwd_a, bus.fwd_b};
            checkOutput({e.name, "/ctrl"}, 32'(act_ctrl), 32'(e.ctrl));
            checkOutput({e.name, "/stall_cnt"}, bus.stall_cnt, e.scnt);
            checkOutput({e.name, "/flush_cnt"}, bus.flush_cnt, e.fcnt);
        end
    end

    localparam logic [10:0] C0  = 11'd0;
    localparam logic [10:0] FRZ = 11'b11_0000_1_00_00;
    localparam logic [10:0] BRM = 11'b00_1111_0_00_00;

    initial begin
        checks = 0;
        errors = 0;
        acc_s  = 0;
        acc_f  = 0;
        reset  = 1'b0;
        bus.d_valid = 0; bus.d_rs = 0; bus.d_rt = 0; bus.d_rs_used = 0; bus.d_rt_used = 0;
        bus.d_dst = 0; bus.d_wen = 0; bus.d_load = 0; bus.d_mem = 0;
        bus.br_taken = 0; bus.mem_ready = 1;
        repeat (2) @(posedge clk);
        $display("[TB] reset released");

        applyStimulus("reset_idle", nop(), 0, 1, 1, C0);

        // lw $8 then a dependent add: two stall cycles, then forward from W
        applyStimulus("lu_issue",  ldw(8, 1),     0, 1, 1, C0);
        applyStimulus("lu_e",      alu(9, 8, 2),  0, 1, 1, ex(1, 0, 1, 0, 0, 0, 2'd0, 2'd0));
        applyStimulus("lu_m",      alu(9, 8, 2),  0, 1, 1, ex(1, 0, 1, 0, 0, 0, 2'd2, 2'd0));
        applyStimulus("lu_fwd_w",  alu(9, 8, 2),  0, 1, 1, ex(0, 0, 0, 0, 0, 0, 2'd3, 2'd0));

        // three writers of $5, then reads with E live, E killed and $0
        applyStimulus("w5_a",      alu(5, 1, 2),  0, 1, 1, C0);
        applyStimulus("w5_b",      alu(5, 1, 2),  0, 1, 1, C0);
        applyStimulus("w5_c",      alu(5, 1, 2),  0, 1, 1, C0);
        applyStimulus("prio_e",    ins(0, 5, 0, 1, 1, 5, 1, 0, 0), 0, 1, 1, ex(0, 0, 0, 0, 0, 0, 2'd1, 2'd0));
        applyStimulus("prio_m",    ins(1, 5, 1, 1, 1, 0, 1, 0, 0), 0, 1, 1, ex(0, 0, 0, 0, 0, 0, 2'd2, 2'd0));
        applyStimulus("r0_and_w",  rdo(0, 5),     0, 1, 1, ex(0, 0, 0, 0, 0, 0, 2'd0, 2'd3));

        // branch resolved in M; a taken request with only E valid is ignored
        applyStimulus("br_issue",  rdo(1, 2),     0, 1, 1, C0);
        applyStimulus("br_in_e",   nop(),         0, 1, 1, C0);
        applyStimulus("br_taken",  nop(),         1, 1, 1, BRM);
        applyStimulus("br_after",  alu(11, 1, 2), 0, 1, 1, C0);
        applyStimulus("br_m_empty", nop(),        1, 1, 1, C0);

        // branch in M, load in E, dependent read in D: flush wins
        applyStimulus("mix_br",    rdo(1, 2),     0, 1, 1, C0);
        applyStimulus("mix_lw",    ldw(8, 1),     0, 1, 1, C0);
        applyStimulus("mix_both",  alu(12, 8, 2), 1, 1, 1, BRM);
        applyStimulus("mix_after", nop(),         0, 1, 1, C0);

        // store in M with memory busy for three cycles
        applyStimulus("fz_w10",    alu(10, 1, 2), 0, 1, 1, C0);
        applyStimulus("fz_st",     st(1, 2),      0, 1, 1, C0);
        applyStimulus("fz_w9",     alu(9, 1, 2),  0, 1, 1, C0);
        applyStimulus("fz_1",      rdo(9, 10),    0, 0, 1, FRZ);
        applyStimulus("fz_2_br",   rdo(9, 10),    1, 0, 1, FRZ);
        applyStimulus("fz_3",      rdo(9, 10),    0, 0, 1, FRZ);
        applyStimulus("fz_held",   rdo(9, 10),    0, 1, 1, ex(0, 0, 0, 0, 0, 0, 2'd1, 2'd0));
        applyStimulus("fz_adv",    rdo(9, 10),    0, 1, 1, ex(0, 0, 0, 0, 0, 0, 2'd2, 2'd0));

        // reset asserted while frozen
        applyStimulus("rz_st",     st(1, 2),      0, 1, 1, C0);
        applyStimulus("rz_gap",    nop(),         0, 1, 1, C0);
        applyStimulus("rz_fz",     rdo(1, 2),     0, 0, 1, FRZ);
        applyStimulus("rz_assert", rdo(1, 2),     0, 0, 0, FRZ);
        applyStimulus("rz_clear",  alu(9, 9, 10), 0, 0, 1, C0);
        applyStimulus("rz_fwd",    rdo(9, 1),     0, 1, 1, ex(0, 0, 0, 0, 0, 0, 2'd1, 2'd0));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
        end
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and flow-control unit for the 5-stage (F/D/E/M/W) pipelined CPU. It keeps its own scoreboard of in-flight instructions in E, M and W, and drives four kinds of pipeline control from it:
- stall/bubble for load-use hazards;
- flush on taken branches/jumps, resolved at a configurable stage;
- a full-pipe freeze while data memory is not ready;
- forwarding selects for the D-stage operand reads.

It sits beside the decoder and drives the enable/clear inputs of the stage registers.

## Interface
- REG_AW, 5, register-address width; register 0 is hard-wired zero.
- RESOLVE_STAGE, 3, stage where branch/jump is resolved: 2 = E, 3 = M.
- CNT_W, 32, width of performance counters.

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low; one clock; reset is synchronous and active-low
- d_valid  in  1  D stage holds a real instruction
- d_rs, d_rt  in  REG_AW  D-stage source registers
- d_rs_used, d_rt_used  in  1  source actually read
- d_dst  in  REG_AW  destination register (after rd/rt select)
- d_wen  in  1  instruction writes register file
- d_load  in  1  instruction is a load
- d_mem  in  1  instruction accesses data memory (load or store)
- br_taken  in  1  redirect request from the RESOLVE_STAGE instruction
- mem_ready  in  1  data memory completes the access this cycle
- stall_f, stall_d  out  1  hold PC and F→D register
- flush_fd, flush_de, flush_em  out  1  clear the named stage register to a bubble
- redirect  out  1  PC takes the branch/jump target this cycle
- freeze  out  1  hold F→D, D→E and E→M registers; M→W loads a bubble
- fwd_a, fwd_b  out  2  operand source: 0 regfile, 1 E result, 2 M result, 3 W result
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Scoreboard entries E, M, W, each holding {valid, dst, wen, load, mem}.
- Matching rule: a source matches a stage when:
  - the source is used;
  - the source register ≠ 0;
  - the stage entry is valid with wen = 1;
  - the stage dst equals the source.
- Forwarding per operand, priority E > M > W > regfile. E is eligible only if its entry is not a load.
- Load-use: a D source matches E or M while that entry has load = 1. This raises stall_f, stall_d and flush_de, so a bubble enters E.
  - Load data is only available from W, so the stall lasts 2 cycles when the load is in E and 1 cycle when it is in M.
- Memory freeze: M entry valid, mem = 1 and mem_ready = 0. Then:
  - freeze = stall_f = stall_d = 1;
  - E and M entries are held;
  - W is loaded invalid.
  - All other hazard outputs are forced to 0.
- Branch: the RESOLVE_STAGE entry is valid and br_taken = 1, with no freeze. Then:
  - redirect = 1, flush_fd = 1, flush_de = 1;
  - flush_em = 1 only when RESOLVE_STAGE = 3.
  - Load-use stall is suppressed that cycle, because the D instruction is killed.
- Priority: freeze > branch flush > load-use stall.
- Scoreboard advance (no freeze):
  - W ← M;
  - M ← bubble if flush_em, else E;
  - E ← bubble if flush_de or load-use, else the D fields with valid = d_valid.
- Counters:
  - stall_cnt increments on any cycle with stall_d = 1.
  - flush_cnt increments on every redirect.
  - Both saturate at all-ones.

## Timing
- Hazard outputs are combinational from the scoreboard and D inputs, with no added latency. The registered scoreboard updates on the edge ending the cycle.
- Reset (reset = 0 at an edge): all entries become invalid and both counters become 0.
  - In the following cycle every output is 0 unless the D inputs create a match, which cannot happen with an empty scoreboard.
- Reset during freeze or stall: cleared immediately; there is no deferred redirect.
- A br_taken that arrives while frozen is ignored until freeze drops. The driver holds br_taken stable, since the stage is held.
- RESOLVE_STAGE is any value other than 2 or 3: elaboration error.

## Structure
- Shared package `pipe_pkg`:
  - fwd_sel encodings FWD_RF/FWD_E/FWD_M/FWD_W;
  - stage indices;
  - scoreboard-entry struct.
- One sub-module, `sb_match`: combinational source-versus-entry comparator, instantiated per source per stage.
- Counters stay inline.

## Test plan
- **Load-use:** lw $8 in E, D add reads $8 → stall_d = 1 for 2 cycles, then fwd_a = 3; stall_cnt = 2.
- **Forward priority:** E, M and W all write $5, D reads $5 → fwd_a = 1. With E killed → fwd_a = 2. Reading $0 → fwd = 0.
- **Branch at M (RESOLVE_STAGE = 3):** br_taken with M valid → redirect, flush_fd, flush_de and flush_em all 1 for one cycle; flush_cnt = 1.
- **Freeze:** M store with mem_ready = 0 for 3 cycles → freeze = 1 for 3 cycles, W invalid, E and M entries unchanged, then normal advance.
- **Simultaneous branch and load-use:** flush wins, stall_d = 0, stall_cnt unchanged.
- **Reset mid-freeze:** reset = 0 during freeze → next cycle all outputs 0 and counters 0.
